uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first, the receive counterpart of the team's UART transmitter on the same serial line format. It sits between the external RX pin and on-chip logic: it synchronises the pin, detects and validates the start bit, samples each bit at its centre, and presents each good byte with a one-cycle valid pulse. Frames with a bad stop bit are dropped and flagged.

---
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 asynchronous serial receiver, LSB first.
//
// Synchronises the RX pin, detects the start bit, validates it at mid-bit,
// samples every data bit and the stop bit at their centres, and presents
// each good byte with a one-cycle valid pulse. A frame whose stop bit reads
// 0 is dropped and flagged with a one-cycle error pulse.
//
// Parameters:
//   CLK   system clock frequency in Hz
//   BAUD  line rate in bit/s
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   uart_data  in   serial line, idle high, asynchronous to clk
//   rx_data    out  [7:0] last correctly received byte
//   rx_valid   out  one-cycle pulse, rx_data just updated with a good byte
//   rx_err     out  one-cycle pulse, frame ended with stop bit = 0
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int CLK  = 50_000_000,
   parameter int BAUD = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_err
);

   localparam int ONEBIT = CLK / BAUD;
   localparam int HALF   = ONEBIT / 2;

   localparam logic [19:0] ONEBIT_LAST = 20'(ONEBIT - 1);
   localparam logic [19:0] HALF_LAST   = 20'(HALF - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t      state_q;
   logic [2:0]  sync_q;        // [0]=s0, [1]=s1 (sampled line), [2]=s2
   logic [19:0] cnt_onebit_q;  // clocks elapsed in the current bit
   logic [3:0]  cnt_q;         // data bit index 0..7
   logic [7:0]  sh_q;          // assembly register for the byte in flight
   logic [7:0]  rx_data_q;
   logic        rx_valid_q;
   logic        rx_err_q;

   logic line;
   logic fall;

   assign line = sync_q[1];
   // Falling edge of the synchronised line; only acted on in IDLE, so a
   // line held low after a framing error cannot retrigger a frame.
   assign fall = sync_q[2] & ~sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the synchroniser resets to the idle-high line level so that
         // releasing reset never looks like a start edge.
         sync_q       <= 3'b111;
         state_q      <= IDLE;
         cnt_onebit_q <= '0;
         cnt_q        <= '0;
         sh_q         <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         rx_err_q     <= 1'b0;
      end else begin
         // NOTE: every register in this block uses <=, so each branch below
         // reads the values from before this edge regardless of order.
         sync_q     <= {sync_q[1:0], uart_data};
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;

         unique case (state_q)
            IDLE: begin
               cnt_onebit_q <= '0;
               if (fall) state_q <= START;
            end

            START: begin
               if (cnt_onebit_q == HALF_LAST) begin
                  cnt_onebit_q <= '0;
                  cnt_q        <= '0;
                  // Still low at mid start bit: real frame. High: glitch.
                  state_q      <= line ? IDLE : DATA;
               end else begin
                  cnt_onebit_q <= cnt_onebit_q + 20'd1;
               end
            end

            DATA: begin
               if (cnt_onebit_q == ONEBIT_LAST) begin
                  cnt_onebit_q      <= '0;
                  sh_q[cnt_q[2:0]]  <= line;
                  if (cnt_q == 4'd7) state_q <= STOP;
                  else               cnt_q   <= cnt_q + 4'd1;
               end else begin
                  cnt_onebit_q <= cnt_onebit_q + 20'd1;
               end
            end

            STOP: begin
               // Leaving at mid stop bit leaves half a bit to catch the
               // next start edge of a back-to-back frame.
               if (cnt_onebit_q == ONEBIT_LAST) begin
                  cnt_onebit_q <= '0;
                  state_q      <= IDLE;
                  if (line) begin
                     rx_data_q  <= sh_q;
                     rx_valid_q <= 1'b1;
                  end else begin
                     rx_err_q   <= 1'b1;
                  end
               end else begin
                  cnt_onebit_q <= cnt_onebit_q + 20'd1;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx at CLK=1600, BAUD=100
// (ONEBIT=16, HALF=8). A bench-side serial driver produces frames; a
// monitor records every rx_valid / rx_err pulse with its clock-edge number.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int  ONEBIT = 16;
   localparam int  HALF   = 8;
   localparam real CLK_NS = 10.0;
   localparam real BIT_NS = 160.0;   // ONEBIT * CLK_NS
   // Edges from the cycle the driver pulls the line low to the edge whose
   // output shows the stop-bit result: 1 + (HALF+3-1) + 9*ONEBIT = 155.
   localparam int  PULSE_LAT = 155;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_data = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;

   uart_rx #(.CLK(1600), .BAUD(100)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart_data (uart_data),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_err    (rx_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- monitor ----------------
   int         edge_cnt = 0;
   int         v_edge[$];
   logic [7:0] v_data[$];
   int         e_edge[$];
   int         both_cnt = 0;
   int         long_cnt = 0;
   logic       prev_v = 1'b0;
   logic       prev_e = 1'b0;

   always @(posedge clk) edge_cnt++;

   always @(negedge clk) begin
      if (rx_valid) begin
         v_edge.push_back(edge_cnt);
         v_data.push_back(rx_data);
      end
      if (rx_err) e_edge.push_back(edge_cnt);
      if (rx_valid && rx_err) both_cnt++;
      if ((rx_valid && prev_v) || (rx_err && prev_e)) long_cnt++;
      prev_v = rx_valid;
      prev_e = rx_err;
   end

   task automatic clear_mon();
      v_edge.delete();
      v_data.delete();
      e_edge.delete();
   endtask

   // ---------------- driver ----------------
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real scale);
      real bt;
      bt = BIT_NS * scale;
      uart_data = 1'b0;
      #(bt);
      for (int i = 0; i < 8; i++) begin
         uart_data = b[i];
         #(bt);
      end
      uart_data = stop_bit;
      #(bt);
      uart_data = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   int         start_e;
   int         start_e2;
   logic [7:0] exp_q[$];
   logic [7:0] rb;
   real        sc;

   initial begin
      // ---- reset state ----
      idle_cycles(3);
      check("rst_data",  32'(rx_data),  32'h00);
      check("rst_valid", 32'(rx_valid), 32'h0);
      check("rst_err",   32'(rx_err),   32'h0);
      rst_n = 1'b1;
      idle_cycles(20);
      check("post_rst_pulses", 32'(v_edge.size() + e_edge.size()), 32'd0);

      // ---- single 0x55, exact timing ----
      clear_mon();
      @(negedge clk);
      start_e = edge_cnt;
      send_frame(8'h55, 1'b1, 1.0);
      idle_cycles(10);
      check("x55_nvalid", 32'(v_data.size()), 32'd1);
      check("x55_nerr",   32'(e_edge.size()), 32'd0);
      if (v_data.size() > 0) begin
         check("x55_data", 32'(v_data[0]), 32'h55);
         check("x55_lat",  32'(v_edge[0] - start_e), 32'(PULSE_LAT));
      end
      check("x55_hold", 32'(rx_data), 32'h55);

      // ---- framing error: 0x81 with stop = 0 ----
      clear_mon();
      @(negedge clk);
      start_e = edge_cnt;
      send_frame(8'h81, 1'b0, 1.0);
      idle_cycles(10);
      check("x81_nerr",   32'(e_edge.size()), 32'd1);
      check("x81_nvalid", 32'(v_data.size()), 32'd0);
      if (e_edge.size() > 0)
         check("x81_err_lat", 32'(e_edge[0] - start_e), 32'(PULSE_LAT));
      check("x81_keep", 32'(rx_data), 32'h55);
      clear_mon();
      @(negedge clk);
      send_frame(8'h7E, 1'b1, 1.0);
      idle_cycles(10);
      check("x7e_nvalid", 32'(v_data.size()), 32'd1);
      if (v_data.size() > 0) check("x7e_data", 32'(v_data[0]), 32'h7E);
      check("x7e_nerr", 32'(e_edge.size()), 32'd0);

      // ---- back-to-back 0xA3, 0x3C ----
      clear_mon();
      @(negedge clk);
      start_e = edge_cnt;
      send_frame(8'hA3, 1'b1, 1.0);
      send_frame(8'h3C, 1'b1, 1.0);
      idle_cycles(10);
      check("b2b_nvalid", 32'(v_data.size()), 32'd2);
      check("b2b_nerr",   32'(e_edge.size()), 32'd0);
      if (v_data.size() > 1) begin
         check("b2b_d0",   32'(v_data[0]), 32'hA3);
         check("b2b_d1",   32'(v_data[1]), 32'h3C);
         check("b2b_lat",  32'(v_edge[0] - start_e), 32'(PULSE_LAT));
         check("b2b_gap",  32'(v_edge[1] - v_edge[0]), 32'(10 * ONEBIT));
      end

      // ---- short glitch (HALF/2 clocks) then 0xFF ----
      clear_mon();
      @(negedge clk);
      uart_data = 1'b0;
      idle_cycles(HALF / 2);
      uart_data = 1'b1;
      idle_cycles(2 * ONEBIT);
      check("glitch_pulses", 32'(v_data.size() + e_edge.size()), 32'd0);
      send_frame(8'hFF, 1'b1, 1.0);
      idle_cycles(10);
      check("xff_nvalid", 32'(v_data.size()), 32'd1);
      if (v_data.size() > 0) check("xff_data", 32'(v_data[0]), 32'hFF);

      // ---- break: line held low for 20 bit times, then 0x5A ----
      clear_mon();
      @(negedge clk);
      uart_data = 1'b0;
      #(20.0 * BIT_NS);
      uart_data = 1'b1;
      idle_cycles(2 * ONEBIT);
      check("brk_nerr",   32'(e_edge.size()), 32'd1);
      check("brk_nvalid", 32'(v_data.size()), 32'd0);
      clear_mon();
      send_frame(8'h5A, 1'b1, 1.0);
      idle_cycles(10);
      check("x5a_nvalid", 32'(v_data.size()), 32'd1);
      if (v_data.size() > 0) check("x5a_data", 32'(v_data[0]), 32'h5A);

      // ---- reset during bit 4 of 0x99, then 0x42 ----
      clear_mon();
      @(negedge clk);
      fork
         send_frame(8'h99, 1'b1, 1.0);
         begin
            #(5.5 * BIT_NS);
            rst_n = 1'b0;
         end
      join
      @(negedge clk);
      check("mid_rst_data", 32'(rx_data), 32'h00);
      idle_cycles(ONEBIT);
      rst_n = 1'b1;
      idle_cycles(2 * ONEBIT);
      check("mid_rst_pulses", 32'(v_data.size() + e_edge.size()), 32'd0);
      check("after_rst_data", 32'(rx_data), 32'h00);
      @(negedge clk);
      start_e2 = edge_cnt;
      send_frame(8'h42, 1'b1, 1.0);
      idle_cycles(10);
      check("x42_nvalid", 32'(v_data.size()), 32'd1);
      if (v_data.size() > 0) begin
         check("x42_data", 32'(v_data[0]), 32'h42);
         check("x42_lat",  32'(v_edge[0] - start_e2), 32'(PULSE_LAT));
      end

      // ---- loopback: 0x00, 0xFF, 256 random, baud cycling 1.00/1.03/0.97 ----
      clear_mon();
      exp_q.delete();
      @(negedge clk);
      send_frame(8'h00, 1'b1, 1.0);
      exp_q.push_back(8'h00);
      send_frame(8'hFF, 1'b1, 1.0);
      exp_q.push_back(8'hFF);
      for (int i = 0; i < 256; i++) begin
         rb = 8'($urandom_range(0, 255));
         case (i % 3)
            0:       sc = 1.0;
            1:       sc = 1.03;
            default: sc = 0.97;
         endcase
         send_frame(rb, 1'b1, sc);
         exp_q.push_back(rb);
      end
      idle_cycles(2 * ONEBIT);
      check("lb_count", 32'(v_data.size()), 32'(exp_q.size()));
      check("lb_nerr",  32'(e_edge.size()), 32'd0);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < v_data.size())
            check($sformatf("lb_byte%0d", i), 32'(v_data[i]), 32'(exp_q[i]));
      end

      // ---- pulse shape over the whole run ----
      check("pulse_overlap", 32'(both_cnt), 32'd0);
      check("pulse_width",   32'(long_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
